tri_assemble: RTL
=================

# tri_assemble

Consumer end of the projected-vertex stream. Accepts 9-bit screen-space vertices (x, y, z) one per handshake from the projection stage and groups every three into a triangle. For each triangle it computes twice the signed area, the winding and a screen-clamped bounding box, then presents the triangle to the rasterizer with a valid/ready handshake. Degenerate and (optionally) back-facing triangles are culled here.

## Interface
- SCREEN_W, 320: screen width in pixels. The bounding-box x range is clamped to [0, SCREEN_W-1].
- SCREEN_H, 240: screen height in pixels. The bounding-box y range is clamped to [0, SCREEN_H-1].
- CULL_DEGEN, 1: when 1, triangles with area == 0 are dropped.
- CULL_BACK, 0: when 1, triangles with area < 0 (clockwise) are dropped.
- clk_in  input  1  single clock.
- rst_in  input  1  asynchronous, active-low reset.
- coor_in [2:0]  input  9 each  vertex; [2]=x, [1]=y, [0]=z, all unsigned.
- valid_in  input  1  vertex beat valid. The producer may pulse it for one cycle.
- obj_done_in  input  1  qualifies the beat; marks the last vertex of an object.
- ready_out  output  1  block can accept a vertex this cycle.
- tri_x_out [2:0], tri_y_out [2:0], tri_z_out [2:0]  output  9 each  vertices v0..v2 in arrival order.
- bb_min_x_out, bb_max_x_out, bb_min_y_out, bb_max_y_out  output  9 each  clamped bounding box.
- area_out  output  21 signed  (x1-x0)(y2-y0) - (x2-x0)(y1-y0).
- cw_out  output  1  1 when area_out < 0.
- valid_out  output  1  triangle valid.
- obj_done_out  output  1  triangle closes an object.
- ready_in  input  1  downstream can take the triangle.
- drop_out  output  1  one-cycle pulse when a partial triangle is discarded.

## Operation
- States: V0, V1, V2, CALC, AREA, OUT.
- ready_out is 1 exactly in V0, V1 and V2.
- A beat is accepted when valid_in && ready_out. On acceptance, the vertex is stored into slot 0, 1 or 2 and the state advances V0→V1→V2→CALC.
- Partial triangle:
  - If obj_done_in is set on a beat accepted in V0 or V1, the stored vertices are discarded and the state returns to V0.
  - drop_out pulses for one cycle and the pending_done flag is set.
- CALC registers the following:
  - dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0, each 10-bit signed.
  - Raw min and max of x and y.
  - The clamped bounding box: a max above the screen limit becomes SCREEN_W-1 or SCREEN_H-1, and the corresponding min is clamped the same way.
- AREA:
  - Registers area = dx1*dy2 - dx2*dy1, computed in full 21-bit signed precision with no saturation. Range is ±522242.
  - done_tri = obj_done of the third beat OR pending_done.
  - Cull check: if (CULL_DEGEN && area==0) or (CULL_BACK && area<0), the triangle is culled and the state goes to V0. pending_done is set to done_tri, so the object end carries over to the next emitted triangle.
  - Otherwise the state goes to OUT.
- OUT:
  - valid_out=1 and all triangle outputs are held stable.
  - obj_done_out = done_tri.
  - When ready_in=1: the triangle transfers, pending_done clears and the state goes to V0.
- Simultaneous events:
  - drop_out and pending_done set in the same cycle is legal.
  - A beat arriving while ready_out=0 is ignored. Producers must wait for ready.

## Timing
- Reset (rst_in=0, asynchronous):
  - State = V0, ready_out=1.
  - valid_out=0, obj_done_out=0, drop_out=0, pending_done=0.
  - All data outputs = 0.
- Reset mid-operation discards every stored vertex and the in-flight triangle.
- Latency: third beat accepted at edge N → CALC during N+1 → AREA during N+2 → valid_out=1 from N+3.
- Culled triangle: ready_out=1 again from N+3.
- After transfer on edge M (valid_out && ready_in): valid_out=0 and ready_out=1 from M+1.
- Minimum period is 6 cycles per triangle.
- drop_out is high for exactly the cycle after the offending beat.

## Test plan
- CCW triangle:
  - Stimulus: beats (10,10,5), (100,10,6), (10,50,7), ready_in=1.
  - Response: area_out=3600, cw_out=0, bb x 10..100, y 10..50, valid_out high for one cycle at N+3.
- CW triangle:
  - Stimulus: (10,10), (10,50), (100,10); once with CULL_BACK=0, once with CULL_BACK=1.
  - Response with CULL_BACK=0: area_out=-3600, cw_out=1.
  - Response with CULL_BACK=1: no valid_out, ready_out=1 at N+3.
- Degenerate:
  - Stimulus: (5,5), (10,10), (15,15) with CULL_DEGEN=1.
  - Response: culled, no valid_out.
  - Repeat with obj_done_in on the third beat: the next good triangle has obj_done_out=1.
- Clamp:
  - Stimulus: (300,200), (400,10), (310,260).
  - Response: bb_max_x=319, bb_max_y=239, bb_min_x=300, bb_min_y=10.
- Partial and backpressure:
  - Stimulus: obj_done_in on the second beat.
  - Response: drop_out pulse; the next triangle carries obj_done_out=1.
  - Stimulus: ready_in=0 for 5 cycles while in OUT.
  - Response: valid_out and the data stay stable, ready_out=0 throughout, and the triangle transfers on the first ready_in=1.
- Reset:
  - Stimulus: rst_in=0 asserted asynchronously after two beats.
  - Response: immediate reset values. The next three beats form a fresh triangle that contains none of the old vertices.

Source files
------------

// File: rtl/tri_assemble.sv
// Groups projected vertices into triangles, computes area/winding/bbox,
// culls degenerate or back-facing ones and hands the rest to the rasterizer.
module tri_assemble #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter bit CULL_DEGEN = 1'b1,
    parameter bit CULL_BACK  = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [2:0][8:0]  coor_in,
    input  logic             valid_in,
    input  logic             obj_done_in,
    output logic             ready_out,
    output logic [2:0][8:0]  tri_x_out,
    output logic [2:0][8:0]  tri_y_out,
    output logic [2:0][8:0]  tri_z_out,
    output logic [8:0]       bb_min_x_out,
    output logic [8:0]       bb_max_x_out,
    output logic [8:0]       bb_min_y_out,
    output logic [8:0]       bb_max_y_out,
    output logic signed [20:0] area_out,
    output logic             cw_out,
    output logic             valid_out,
    output logic             obj_done_out,
    input  logic             ready_in,
    output logic             drop_out
);

    typedef enum logic [2:0] {V0, V1, V2, CALC, AREA, OUT} state_t;

    localparam logic [8:0] LIM_X = 9'(SCREEN_W - 1);
    localparam logic [8:0] LIM_Y = 9'(SCREEN_H - 1);

    state_t              state_q;
    logic [2:0][8:0]     x_q, y_q, z_q;
    logic signed [9:0]   dx1_q, dy1_q, dx2_q, dy2_q;
    logic signed [9:0]   dx1_d, dy1_d, dx2_d, dy2_d;
    logic [8:0]          bminx_q, bmaxx_q, bminy_q, bmaxy_q;
    logic [8:0]          bminx_d, bmaxx_d, bminy_d, bmaxy_d;
    logic signed [20:0]  area_q, area_d;
    logic                cw_q, valid_q, done_q, drop_q;
    logic                done3_q, pending_q;
    logic                beat, cull, done_tri;

    function automatic logic [8:0] min3(input logic [8:0] a, b, c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, b, c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [8:0] clamp(input logic [8:0] v, lim);
        return (v > lim) ? lim : v;
    endfunction

    always_comb begin
        dx1_d   = 10'(x_q[1]) - 10'(x_q[0]);
        dy1_d   = 10'(y_q[1]) - 10'(y_q[0]);
        dx2_d   = 10'(x_q[2]) - 10'(x_q[0]);
        dy2_d   = 10'(y_q[2]) - 10'(y_q[0]);
        bminx_d = clamp(min3(x_q[0], x_q[1], x_q[2]), LIM_X);
        bmaxx_d = clamp(max3(x_q[0], x_q[1], x_q[2]), LIM_X);
        bminy_d = clamp(min3(y_q[0], y_q[1], y_q[2]), LIM_Y);
        bmaxy_d = clamp(max3(y_q[0], y_q[1], y_q[2]), LIM_Y);
        // Sign-extend before multiplying so the full 21-bit result survives
        area_d  = 21'(dx1_q) * 21'(dy2_q) - 21'(dx2_q) * 21'(dy1_q);
        cull    = (CULL_DEGEN && (area_d == 21'sd0)) ||
                  (CULL_BACK && (area_d < 21'sd0));
        done_tri = done3_q | pending_q;
    end

    assign beat      = valid_in && ready_out;
    assign ready_out = (state_q == V0) || (state_q == V1) || (state_q == V2);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= V0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            dx1_q     <= '0;
            dy1_q     <= '0;
            dx2_q     <= '0;
            dy2_q     <= '0;
            bminx_q   <= '0;
            bmaxx_q   <= '0;
            bminy_q   <= '0;
            bmaxy_q   <= '0;
            area_q    <= '0;
            cw_q      <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            done3_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            unique case (state_q)
                V0, V1: begin
                    if (beat) begin
                        x_q[state_q == V1] <= coor_in[2];
                        y_q[state_q == V1] <= coor_in[1];
                        z_q[state_q == V1] <= coor_in[0];
                        if (obj_done_in) begin
                            drop_q    <= 1'b1;
                            pending_q <= 1'b1;
                            state_q   <= V0;
                        end else begin
                            state_q <= (state_q == V0) ? V1 : V2;
                        end
                    end
                end
                V2: begin
                    if (beat) begin
                        x_q[2]  <= coor_in[2];
                        y_q[2]  <= coor_in[1];
                        z_q[2]  <= coor_in[0];
                        done3_q <= obj_done_in;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    dx1_q   <= dx1_d;
                    dy1_q   <= dy1_d;
                    dx2_q   <= dx2_d;
                    dy2_q   <= dy2_d;
                    bminx_q <= bminx_d;
                    bmaxx_q <= bmaxx_d;
                    bminy_q <= bminy_d;
                    bmaxy_q <= bmaxy_d;
                    state_q <= AREA;
                end
                AREA: begin
                    area_q <= area_d;
                    cw_q   <= area_d < 21'sd0;
                    if (cull) begin
                        // Object end rides on the next emitted triangle
                        pending_q <= done_tri;
                        state_q   <= V0;
                    end else begin
                        done_q  <= done_tri;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (ready_in) begin
                        valid_q   <= 1'b0;
                        done_q    <= 1'b0;
                        pending_q <= 1'b0;
                        state_q   <= V0;
                    end
                end
                default: state_q <= V0;
            endcase
        end
    end

    assign tri_x_out    = x_q;
    assign tri_y_out    = y_q;
    assign tri_z_out    = z_q;
    assign bb_min_x_out = bminx_q;
    assign bb_max_x_out = bmaxx_q;
    assign bb_min_y_out = bminy_q;
    assign bb_max_y_out = bmaxy_q;
    assign area_out     = area_q;
    assign cw_out       = cw_q;
    assign valid_out    = valid_q;
    assign obj_done_out = done_q;
    assign drop_out     = drop_q;

endmodule
